wb_mtimer: RTL

- Wishbone B4 classic slave providing a RISC-V style machine timer: 64-bit free-running mtime, 64-bit mtimecmp and a programmable prescaler.
- Drives the core's interrupt_timer input directly, replacing the UART interrupt currently tied to that pin.
- Sits on the data bus behind the intercon as slave "mtimer"; instruction bus never targets it.

---
 rtl/wb_mtimer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/wb_mtimer.sv
// Wishbone B4 classic machine timer: 64-bit mtime/mtimecmp, prescaled tick,
// shadowed high half for coherent 64-bit reads, level interrupt to the core.
module wb_mtimer #(
   parameter int                    PRESCALE_W   = 16,
   parameter logic [PRESCALE_W-1:0] PRESCALE_RST = '0
) (
   input  logic        wb_clk,
   input  logic        wb_rst_n,
   input  logic [31:0] wb_adr,
   input  logic [31:0] wb_dat,
   input  logic [3:0]  wb_sel,
   input  logic        wb_we,
   input  logic        wb_cyc,
   input  logic        wb_stb,
   output logic [31:0] wb_rdt,
   output logic        wb_ack,
   output logic        o_timer_irq
);

   logic [63:0]           r_mtime;
   logic [31:0]           r_shadow_hi;
   logic [63:0]           r_mtimecmp;
   logic                  r_cnt_en;
   logic                  r_irq_en;
   logic [PRESCALE_W-1:0] r_prescale;
   logic [PRESCALE_W-1:0] r_pcnt;
   logic                  r_ack;
   logic [31:0]           r_rdt;
   logic                  r_irq;

   logic        w_req, w_wr, w_rd, w_tick;
   logic [2:0]  w_idx;
   logic [31:0] w_rdmux;
   logic [31:0] w_pre_merged;
   logic        w_unused;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] m;
      m = old;
      for (int b = 0; b < 4; b++)
         if (s[b]) m[b*8 +: 8] = d[b*8 +: 8];
      return m;
   endfunction

   assign w_idx    = wb_adr[4:2];
   assign w_unused = ^{wb_adr[31:5], wb_adr[1:0]};
   assign w_req    = wb_cyc & wb_stb & ~r_ack;
   assign w_wr     = w_req & wb_we & (|wb_sel);
   assign w_rd     = w_req & ~wb_we;
   assign w_tick   = r_cnt_en & (r_pcnt == r_prescale);

   assign w_pre_merged = merge(32'(r_prescale), wb_dat, wb_sel);

   always_comb begin
      w_rdmux = 32'd0;
      case (w_idx)
         3'd0: w_rdmux = r_mtime[31:0];
         3'd1: w_rdmux = r_shadow_hi;
         3'd2: w_rdmux = r_mtimecmp[31:0];
         3'd3: w_rdmux = r_mtimecmp[63:32];
         3'd4: w_rdmux = {30'd0, r_irq_en, r_cnt_en};
         3'd5: w_rdmux = 32'(r_prescale);
         default: w_rdmux = 32'd0;
      endcase
   end

   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         r_mtime     <= 64'd0;
         r_shadow_hi <= 32'd0;
         r_mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
         r_cnt_en    <= 1'b0;
         r_irq_en    <= 1'b0;
         r_prescale  <= PRESCALE_RST;
         r_pcnt      <= '0;
         r_ack       <= 1'b0;
         r_rdt       <= 32'd0;
         r_irq       <= 1'b0;
      end else begin
         r_ack <= w_req;

         if (w_rd) begin
            r_rdt <= w_rdmux;
            if (w_idx == 3'd0) r_shadow_hi <= r_mtime[63:32];
         end

         // A bus write to either half of mtime suppresses that edge's tick entirely.
         if (w_wr && w_idx == 3'd0)
            r_mtime[31:0] <= merge(r_mtime[31:0], wb_dat, wb_sel);
         else if (w_wr && w_idx == 3'd1)
            r_mtime[63:32] <= merge(r_mtime[63:32], wb_dat, wb_sel);
         else if (w_tick)
            r_mtime <= r_mtime + 64'd1;

         if (w_wr && w_idx == 3'd2)
            r_mtimecmp[31:0] <= merge(r_mtimecmp[31:0], wb_dat, wb_sel);
         if (w_wr && w_idx == 3'd3)
            r_mtimecmp[63:32] <= merge(r_mtimecmp[63:32], wb_dat, wb_sel);

         if (w_wr && w_idx == 3'd4 && wb_sel[0]) begin
            r_cnt_en <= wb_dat[0];
            r_irq_en <= wb_dat[1];
         end

         if (w_wr && w_idx == 3'd5) begin
            r_prescale <= w_pre_merged[PRESCALE_W-1:0];
            r_pcnt     <= '0;
         end else if (r_cnt_en) begin
            r_pcnt <= w_tick ? '0 : r_pcnt + PRESCALE_W'(1);
         end

         r_irq <= r_irq_en & (r_mtime >= r_mtimecmp);
      end
   end

   assign wb_ack      = r_ack;
   assign wb_rdt      = r_rdt;
   assign o_timer_irq = r_irq;

endmodule
